// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and constants for the CPU control sequencer.
package cpu_ctrl_pkg;

  localparam int OPCODE_BITS = 4;
  localparam int CTRL_BITS   = 16;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_JC  = 4'h7,
    OP_JZ  = 4'h8,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {T0, T1, T2, T3, T4} step_t;

  typedef struct packed {
    logic halt;
    logic mar_in;
    logic ram_in;
    logic ram_out;
    logic ir_in;
    logic ir_out;
    logic a_in;
    logic a_out;
    logic alu_out;
    logic alu_sub;
    logic b_in;
    logic out_in;
    logic pc_inc;
    logic pc_jump;
    logic pc_out;
    logic flags_in;
  } ctrl_t;

  localparam step_t LAST_SHORT = T2;
  localparam step_t LAST_MEM   = T3;
  localparam step_t LAST_ALU   = T4;

  function automatic step_t last_step_of(opcode_t op);
    case (op)
      OP_LDA, OP_STA: return LAST_MEM;
      OP_ADD, OP_SUB: return LAST_ALU;
      default:        return LAST_SHORT;
    endcase
  endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// rtl/cpu_control_unit_if.sv - sequencer inputs and control/status outputs.
interface cpu_control_unit_if;
  logic                                step_en;
  logic [cpu_ctrl_pkg::OPCODE_BITS-1:0] opcode;
  logic                                carry;
  logic                                zero;
  logic [cpu_ctrl_pkg::CTRL_BITS-1:0]   ctrl;
  logic [2:0]                          step;
  logic                                halted;

  modport master (output step_en, opcode, carry, zero, input ctrl, step, halted);
  modport slave  (input step_en, opcode, carry, zero, output ctrl, step, halted);
endinterface

// File: rtl/cpu_microcode_rom.sv
// rtl/cpu_microcode_rom.sv - combinational microcode decode of (step, opcode, flags).
// With SKIP_IDLE_STEPS_EN defined it also reports the instruction's last used step.
module cpu_microcode_rom
  import cpu_ctrl_pkg::*;
(
  input  logic [2:0] step,
  input  opcode_t    opcode,
  input  logic       carry,
  input  logic       zero,
`ifdef SKIP_IDLE_STEPS_EN
  output logic       last_step,
`endif
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (step)
      3'd0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
      end
      3'd1: begin
        ctrl.ram_out = 1'b1;
        ctrl.ir_in   = 1'b1;
        ctrl.pc_inc  = 1'b1;
      end
      3'd2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ctrl.ir_out = 1'b1;
            ctrl.mar_in = 1'b1;
          end
          OP_LDI: begin
            ctrl.ir_out = 1'b1;
            ctrl.a_in   = 1'b1;
          end
          OP_JMP: begin
            ctrl.ir_out  = 1'b1;
            ctrl.pc_jump = 1'b1;
          end
          // Conditional jumps look at the flags live in this same cycle.
          OP_JC: begin
            ctrl.ir_out  = carry;
            ctrl.pc_jump = carry;
          end
          OP_JZ: begin
            ctrl.ir_out  = zero;
            ctrl.pc_jump = zero;
          end
          OP_OUT: begin
            ctrl.a_out  = 1'b1;
            ctrl.out_in = 1'b1;
          end
          OP_HLT:  ctrl.halt = 1'b1;
          default: ;
        endcase
      end
      3'd3: begin
        case (opcode)
          OP_LDA: begin
            ctrl.ram_out = 1'b1;
            ctrl.a_in    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl.ram_out = 1'b1;
            ctrl.b_in    = 1'b1;
          end
          OP_STA: begin
            ctrl.a_out  = 1'b1;
            ctrl.ram_in = 1'b1;
          end
          default: ;
        endcase
      end
      3'd4: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          ctrl.alu_out  = 1'b1;
          ctrl.a_in     = 1'b1;
          ctrl.flags_in = 1'b1;
          ctrl.alu_sub  = (opcode == OP_SUB);
        end
      end
      default: ;
    endcase
  end

`ifdef SKIP_IDLE_STEPS_EN
  // The IR only holds the new opcode from T2 on, so fetch steps never end an instruction.
  assign last_step = (step >= 3'd2) && (step == 3'(last_step_of(opcode)));
`endif

endmodule

// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - T-state sequencer with halt latch and gated control word.
// Define SKIP_IDLE_STEPS_EN to return to T0 right after each instruction's last used step.
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W  = 4,
  parameter int NUM_STEPS = 5,
  parameter int CTRL_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  cpu_control_unit_if.slave   bus
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_STEPS - 1);

  logic [OPCODE_W-1:0] opcode_raw;
  opcode_t             op;
  ctrl_t               rom_ctrl;
  ctrl_t               ctrl_out;
  logic [CTRL_W-1:0]   ctrl_word;
  logic [2:0]          step_q, step_d;
  logic                halted_q, halted_d;
  logic                end_of_instr;
  logic                halting;
`ifdef SKIP_IDLE_STEPS_EN
  logic                rom_last_step;
`endif

  assign opcode_raw = bus.opcode;
  assign op         = opcode_t'(opcode_raw);

  cpu_microcode_rom u_rom (
    .step      (step_q),
    .opcode    (op),
    .carry     (bus.carry),
    .zero      (bus.zero),
`ifdef SKIP_IDLE_STEPS_EN
    .last_step (rom_last_step),
`endif
    .ctrl      (rom_ctrl)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_q   <= 3'd0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    end_of_instr = (step_q == LAST_IDX);
`ifdef SKIP_IDLE_STEPS_EN
    end_of_instr = end_of_instr || rom_last_step;
`endif
    halting  = (step_q == 3'd2) && (op == OP_HLT);
    step_d   = step_q;
    halted_d = halted_q;
    // Halting freezes the counter on T2 instead of advancing it.
    if (!halted_q && bus.step_en) begin
      if (halting) begin
        halted_d = 1'b1;
      end else begin
        step_d = end_of_instr ? 3'd0 : step_q + 3'd1;
      end
    end
  end

  always_comb begin
    ctrl_out = '0;
    if (rst) begin
      if (halted_q) begin
        ctrl_out.halt = 1'b1;
      end else if (bus.step_en) begin
        ctrl_out = rom_ctrl;
      end
    end
  end

  assign ctrl_word  = ctrl_out;
  assign bus.ctrl   = ctrl_word;
  assign bus.step   = step_q;
  assign bus.halted = halted_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb/tb_cpu_control_unit.sv - directed self-checking bench for cpu_control_unit.
module tb_cpu_control_unit;

  logic clk = 1'b0;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   pc_inc_seen = 0;
  int   base;

  cpu_control_unit_if bus ();

  cpu_control_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.ctrl[3]) pc_inc_seen++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string tag, input logic [3:0] op, input logic cy, input logic zr,
                           input logic [15:0] e2, input logic [15:0] e3, input logic [15:0] e4,
                           input int last);
    logic [15:0] ex [5];
    int          last_eff;
    ex = '{16'h4002, 16'h1808, e2, e3, e4};
    last_eff = 4;
`ifdef SKIP_IDLE_STEPS_EN
    last_eff = last;
`endif
    bus.opcode  = op;
    bus.carry   = cy;
    bus.zero    = zr;
    bus.step_en = 1'b1;
    #1;
    for (int s = 0; s <= last_eff; s++) begin
      check({tag, "_step"}, 32'(bus.step), 32'(s));
      check({tag, "_ctrl"}, 32'(bus.ctrl), 32'(ex[s]));
      if (s > last) check({tag, "_idle"}, 32'(bus.ctrl), 32'h0);
      tick();
    end
    check({tag, "_wrap"}, 32'(bus.step), 32'h0);
  endtask

  initial begin
    rst         = 1'b0;
    bus.step_en = 1'b1;
    bus.opcode  = 4'h5;
    bus.carry   = 1'b0;
    bus.zero    = 1'b0;
    #12;
    check("rst_step",   32'(bus.step),   32'h0);
    check("rst_halted", 32'(bus.halted), 32'h0);
    check("rst_ctrl",   32'(bus.ctrl),   32'h0);
    rst = 1'b1;

    run_instr("ldi",   4'h5, 1'b0, 1'b0, 16'h0600, 16'h0000, 16'h0000, 2);
    run_instr("lda",   4'h1, 1'b0, 1'b0, 16'h4400, 16'h1200, 16'h0000, 3);
    run_instr("add",   4'h2, 1'b0, 1'b0, 16'h4400, 16'h1020, 16'h0281, 4);
    run_instr("sub",   4'h3, 1'b1, 1'b1, 16'h4400, 16'h1020, 16'h02C1, 4);
    run_instr("sta",   4'h4, 1'b0, 1'b0, 16'h4400, 16'h2100, 16'h0000, 3);
    run_instr("jmp",   4'h6, 1'b0, 1'b0, 16'h0404, 16'h0000, 16'h0000, 2);
    run_instr("jc0",   4'h7, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 2);
    run_instr("jc1",   4'h7, 1'b1, 1'b0, 16'h0404, 16'h0000, 16'h0000, 2);
    run_instr("jz0",   4'h8, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 2);
    run_instr("jz1",   4'h8, 1'b0, 1'b1, 16'h0404, 16'h0000, 16'h0000, 2);
    run_instr("out",   4'hE, 1'b0, 1'b0, 16'h0110, 16'h0000, 16'h0000, 2);
    run_instr("nop",   4'h0, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 2);
    run_instr("undef", 4'hB, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 2);

    // step_en held low in the middle of an LDA fetch
    base        = pc_inc_seen;
    bus.opcode  = 4'h1;
    bus.step_en = 1'b1;
    #1;
    check("hold_t0_ctrl", 32'(bus.ctrl), 32'h4002);
    tick();
    bus.step_en = 1'b0;
    #1;
    check("hold_ctrl0", 32'(bus.ctrl), 32'h0);
    check("hold_step0", 32'(bus.step), 32'h1);
    tick();
    check("hold_ctrl1", 32'(bus.ctrl), 32'h0);
    check("hold_step1", 32'(bus.step), 32'h1);
    bus.step_en = 1'b1;
    #1;
    check("hold_t1_ctrl", 32'(bus.ctrl), 32'h1808);
    tick();
    check("hold_t2_step", 32'(bus.step), 32'h2);
    check("hold_t2_ctrl", 32'(bus.ctrl), 32'h4400);
    tick();
    check("hold_t3_ctrl", 32'(bus.ctrl), 32'h1200);
    tick();
`ifndef SKIP_IDLE_STEPS_EN
    check("hold_t4_step", 32'(bus.step), 32'h4);
    tick();
`endif
    check("hold_wrap", 32'(bus.step), 32'h0);
    check("pc_inc_once", 32'(pc_inc_seen - base), 32'h1);

    // asynchronous reset in T3 of STA
    bus.opcode = 4'h4;
    #1;
    tick();
    tick();
    tick();
    check("sta_t3_ctrl", 32'(bus.ctrl), 32'h2100);
    #2;
    rst = 1'b0;
    #1;
    check("async_ctrl", 32'(bus.ctrl), 32'h0);
    check("async_step", 32'(bus.step), 32'h0);
    #1;
    rst = 1'b1;

    // random opcodes/flags, HLT excluded so the run keeps stepping
    for (int i = 0; i < 10000; i++) begin
      bus.opcode  = 4'($urandom_range(0, 14));
      bus.carry   = 1'($urandom);
      bus.zero    = 1'($urandom);
      bus.step_en = 1'($urandom);
      #1;
      check("bus_onehot",
            32'($countones({bus.ctrl[1], bus.ctrl[12], bus.ctrl[10], bus.ctrl[8], bus.ctrl[7]}) <= 1),
            32'h1);
      tick();
    end
    check("rand_not_halted", 32'(bus.halted), 32'h0);
    rst = 1'b0;
    #1;
    rst = 1'b1;

    // HLT latches on the T2 edge and only reset releases it
    bus.opcode  = 4'hF;
    bus.step_en = 1'b1;
    #1;
    check("hlt_t0_ctrl", 32'(bus.ctrl), 32'h4002);
    tick();
    check("hlt_t1_ctrl", 32'(bus.ctrl), 32'h1808);
    tick();
    check("hlt_t2_ctrl",   32'(bus.ctrl),   32'h8000);
    check("hlt_t2_halted", 32'(bus.halted), 32'h0);
    tick();
    check("hlt_halted", 32'(bus.halted), 32'h1);
    check("hlt_step",   32'(bus.step),   32'h2);
    for (int i = 0; i < 20; i++) begin
      bus.step_en = 1'($urandom);
      bus.opcode  = 4'($urandom);
      tick();
      check("hlt_freeze_step", 32'(bus.step), 32'h2);
      check("hlt_freeze_ctrl", 32'(bus.ctrl), 32'h8000);
    end
    #2;
    rst = 1'b0;
    #1;
    check("hlt_rst_step",   32'(bus.step),   32'h0);
    check("hlt_rst_halted", 32'(bus.halted), 32'h0);
    check("hlt_rst_ctrl",   32'(bus.ctrl),   32'h0);
    #1;
    rst = 1'b1;
    run_instr("post_hlt", 4'h5, 1'b0, 1'b0, 16'h0600, 16'h0000, 16'h0000, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
